// File: rtl/mstream_pkg.sv
// mstream_pkg: MSTREAM constants, FSM state type and the pad-check helper.
// Both the pattern driver and the capture side share this package.
package mstream_pkg;
    localparam int MSTREAM_CH     = 20;
    localparam int MSTREAM_DATA   = 16;
    localparam int MSTREAM_PAD_LO = 2;
    localparam int MSTREAM_PAD_HI = 2;
    localparam int MSTREAM_BEAT   = 2 * MSTREAM_DATA;
    localparam int MSTREAM_WORD   = 256;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} cap_state_e;

    // Low pads duplicate the lowest data channel; high pads duplicate the highest one.
    function automatic logic pad_bad(input logic [MSTREAM_CH-1:0] c);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < MSTREAM_PAD_LO; i++)
            bad |= c[i] != c[MSTREAM_PAD_LO];
        for (int i = 0; i < MSTREAM_PAD_HI; i++)
            bad |= c[MSTREAM_CH-1-i] != c[MSTREAM_CH-1-MSTREAM_PAD_HI];
        return bad;
    endfunction
endpackage

// File: rtl/mstream_capture_if.sv
// mstream_capture_if: de-serialised MSTREAM beat input plus capture FIFO write port.
//   stream_en/mstream_rise/mstream_fall : beat valid and rising/falling-edge channel samples
//   dout/wr_en/full                     : 256-bit capture word, write strobe, FIFO almost_full
interface mstream_capture_if;
    import mstream_pkg::*;
    logic                    stream_en;
    logic [MSTREAM_CH-1:0]   mstream_rise;
    logic [MSTREAM_CH-1:0]   mstream_fall;
    logic [MSTREAM_WORD-1:0] dout;
    logic                    wr_en;
    logic                    full;

    modport master (output stream_en, mstream_rise, mstream_fall, full, input dout, wr_en);
    modport slave  (input stream_en, mstream_rise, mstream_fall, full, output dout, wr_en);
endinterface

// File: rtl/mstream_lane_decode.sv
// mstream_lane_decode: strips the pad channels from one rise/fall sample pair.
//   i_rise/i_fall : 20-channel samples from each clock edge
//   o_beat        : 32-bit beat, rising-edge data in [15:0], falling-edge data in [31:16]
//   o_pad_err     : a pad channel disagrees with its data neighbour on either edge
module mstream_lane_decode
    import mstream_pkg::*;
(
    input  logic [MSTREAM_CH-1:0]   i_rise,
    input  logic [MSTREAM_CH-1:0]   i_fall,
    output logic [MSTREAM_BEAT-1:0] o_beat,
    output logic                    o_pad_err
);
    assign o_beat    = {i_fall[MSTREAM_PAD_LO +: MSTREAM_DATA], i_rise[MSTREAM_PAD_LO +: MSTREAM_DATA]};
    assign o_pad_err = pad_bad(i_rise) | pad_bad(i_fall);
endmodule

// File: rtl/mstream_capture.sv
// mstream_capture: decodes MSTREAM beats, packs 8 beats MSB-first into 256-bit words and writes a capture FIFO.
//   clk, reset          : clock and synchronous active-high reset
//   start, Num_Pat      : arm a run of Num_Pat words (0 = free-run)
//   bus                 : beat input and FIFO write port
//   busy, done          : in CAPTURE / in DONE
//   overflow, pad_err   : sticky drop and pad-mismatch flags
//   pad_err_cnt         : saturating count of mismatching beats
//   word_cnt            : words actually written
module mstream_capture
    import mstream_pkg::*;
#(
    parameter int BEATS_PER_WORD = 8,
    parameter int ERRCNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         Num_Pat,
    mstream_capture_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                pad_err,
    output logic [ERRCNT_W-1:0] pad_err_cnt,
    output logic [31:0]         word_cnt
);
    localparam int IDX_W = $clog2(BEATS_PER_WORD);

    cap_state_e              r_state, w_next;
    logic [IDX_W-1:0]        r_idx;
    logic [MSTREAM_WORD-1:0] r_word, r_dout, w_word_next;
    logic                    r_wr_en, r_overflow, r_pad_err;
    logic [ERRCNT_W-1:0]     r_pad_err_cnt;
    logic [31:0]             r_word_cnt, r_issued, r_num_pat;
    logic [MSTREAM_BEAT-1:0] w_beat;
    logic                    w_pad_bad, w_accept, w_last, w_final, w_start_ok;

    mstream_lane_decode u_dec (
        .i_rise    (bus.mstream_rise),
        .i_fall    (bus.mstream_fall),
        .o_beat    (w_beat),
        .o_pad_err (w_pad_bad)
    );

    assign w_accept    = r_state == CAPTURE && bus.stream_en;
    assign w_last      = w_accept && r_idx == IDX_W'(BEATS_PER_WORD - 1);
    // Shifting in at the bottom leaves beat 0 in the top slot once the word is complete.
    assign w_word_next = {r_word[MSTREAM_WORD-MSTREAM_BEAT-1:0], w_beat};
    // The run ends on the Num_Pat-th issued word, whether it was written or dropped.
    assign w_final     = w_last && r_num_pat != 32'd0 && r_issued + 32'd1 == r_num_pat;
    assign w_start_ok  = start && r_state != CAPTURE;

    always_comb begin
        w_next = r_state;
        if (r_state == CAPTURE)
            w_next = w_final ? DONE : CAPTURE;
        else if (start)
            w_next = CAPTURE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_word        <= '0;
            r_dout        <= '0;
            r_wr_en       <= 1'b0;
            r_overflow    <= 1'b0;
            r_pad_err     <= 1'b0;
            r_pad_err_cnt <= '0;
            r_word_cnt    <= '0;
            r_issued      <= '0;
            r_num_pat     <= '0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_last && !bus.full;
            if (w_start_ok) begin
                r_idx         <= '0;
                r_word_cnt    <= '0;
                r_issued      <= '0;
                r_overflow    <= 1'b0;
                r_pad_err     <= 1'b0;
                r_pad_err_cnt <= '0;
                r_num_pat     <= Num_Pat;
            end
            if (w_accept) begin
                r_word <= w_word_next;
                r_idx  <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_pad_bad) begin
                    r_pad_err <= 1'b1;
                    if (~&r_pad_err_cnt)
                        r_pad_err_cnt <= r_pad_err_cnt + ERRCNT_W'(1);
                end
            end
            if (w_last) begin
                r_issued <= r_issued + 32'd1;
                if (!bus.full) begin
                    r_dout     <= w_word_next;
                    r_word_cnt <= r_word_cnt + 32'd1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.dout    = r_dout;
    assign bus.wr_en   = r_wr_en;
    assign busy        = r_state == CAPTURE;
    assign done        = r_state == DONE;
    assign overflow    = r_overflow;
    assign pad_err     = r_pad_err;
    assign pad_err_cnt = r_pad_err_cnt;
    assign word_cnt    = r_word_cnt;
endmodule

// File: tb/tb_mstream_capture.sv
// tb_mstream_capture: scoreboard bench for mstream_capture.
module tb_mstream_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] Num_Pat = '0;
    logic        busy, done, overflow, pad_err;
    logic [15:0] pad_err_cnt;
    logic [31:0] word_cnt;

    int checks = 0;
    int failures = 0;
    int n_wr = 0;
    int b_idx = 0;
    int snap;
    logic [255:0] exp_w = '0;
    logic [255:0] sb_q[$];

    mstream_capture_if bus();

    mstream_capture #(.BEATS_PER_WORD(8), .ERRCNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Num_Pat     (Num_Pat),
        .bus         (bus.slave),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .pad_err     (pad_err),
        .pad_err_cnt (pad_err_cnt),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Pads copy the neighbouring data bit: ch0,1 = ch2 and ch18,19 = ch17.
    function automatic logic [19:0] enc(input logic [15:0] d);
        return {d[15], d[15], d, d[0], d[0]};
    endfunction

    always @(negedge clk) begin
        if (bus.wr_en) begin
            n_wr++;
            if (sb_q.size() == 0)
                check("unexp_wr", 1, 0);
            else
                check("word", bus.dout, sb_q.pop_front());
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.stream_en = 1'b0;
        tick(2);
        reset = 1'b0;
        b_idx = 0;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        Num_Pat = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        b_idx = 0;
    endtask

    // Drives one beat; the expected word is queued when its last beat goes out while full is low.
    task automatic send(input logic [31:0] beat, input bit bad, input bit gap);
        bus.mstream_rise = enc(beat[15:0]);
        bus.mstream_fall = enc(beat[31:16]);
        if (bad) bus.mstream_rise[19] = ~bus.mstream_rise[19];
        bus.stream_en = 1'b1;
        exp_w[255-32*b_idx -: 32] = beat;
        if (b_idx == 7) begin
            if (!bus.full) sb_q.push_back(exp_w);
            b_idx = 0;
        end else begin
            b_idx++;
        end
        tick(1);
        if (gap) begin
            bus.stream_en = 1'b0;
            tick(1);
        end
    endtask

    task automatic idle_bus();
        bus.stream_en = 1'b0;
        tick(2);
    endtask

    initial begin
        bus.stream_en = 1'b0;
        bus.mstream_rise = '0;
        bus.mstream_fall = '0;
        bus.full = 1'b0;
        do_reset();
        check("rst_dout", bus.dout, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_flags", {busy, done, overflow, pad_err}, 0);
        check("rst_cnts", {pad_err_cnt, word_cnt}, 0);

        // two words of a fixed pattern
        pulse_start(2);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 16; i++) send(32'h5A5AA5A5, 0, 0);
        idle_bus();
        check("t1_done", {busy, done}, 2'b01);
        check("t1_word_cnt", word_cnt, 2);
        check("t1_nwr", n_wr, 2);

        // beat ordering, restarted from DONE
        pulse_start(1);
        check("t2_busy", {busy, done, word_cnt}, {2'b10, 32'd0});
        for (int i = 0; i < 8; i++) send(32'h11111111 * i, 0, 0);
        idle_bus();
        check("t2_top", bus.dout[255:224], 32'h00000000);
        check("t2_bot", bus.dout[31:0], 32'h77777777);

        // gapped stream
        snap = n_wr;
        pulse_start(1);
        for (int i = 0; i < 8; i++) send(32'h11111111 * i, 0, 1);
        idle_bus();
        check("t3_nwr", n_wr - snap, 1);
        check("t3_done", done, 1);

        // dropped middle word; a start mid-run must be ignored
        snap = n_wr;
        pulse_start(3);
        for (int i = 0; i < 8; i++) send(32'hC0DE0000 + i, 0, 0);
        bus.full = 1'b1;
        for (int i = 0; i < 4; i++) send(32'hDEAD0000 + i, 0, 0);
        bus.stream_en = 1'b0;
        pulse_start(1);
        b_idx = 4;
        for (int i = 4; i < 8; i++) send(32'hDEAD0000 + i, 0, 0);
        bus.full = 1'b0;
        check("t4_mid_busy", {busy, overflow}, 2'b11);
        for (int i = 0; i < 8; i++) send(32'hBEEF0000 + i, 0, 0);
        idle_bus();
        check("t4_nwr", n_wr - snap, 2);
        check("t4_ovf", overflow, 1);
        check("t4_word_cnt", word_cnt, 2);
        check("t4_done", done, 1);

        // pad errors on three beats; start clears the sticky overflow
        pulse_start(1);
        check("t5_clear", {overflow, pad_err, pad_err_cnt}, 0);
        for (int i = 0; i < 8; i++) send(32'h12345678 ^ i, i == 1 || i == 4 || i == 6, 0);
        idle_bus();
        check("t5_pad_err", pad_err, 1);
        check("t5_pad_cnt", pad_err_cnt, 3);

        // free-run, then reset mid-word
        pulse_start(0);
        for (int i = 0; i < 12; i++) send(32'hF0F00000 + i, 0, 0);
        bus.stream_en = 1'b0;
        tick(1);
        check("t6_freerun", {busy, done, word_cnt}, {2'b10, 32'd1});
        snap = n_wr;
        do_reset();
        tick(10);
        check("t6_no_wr", n_wr - snap, 0);
        check("t6_rst", {busy, done, word_cnt}, 0);
        pulse_start(1);
        for (int i = 0; i < 8; i++) send(32'hA0000000 + 32'h01010101 * i, 0, 0);
        idle_bus();
        check("t6_done", {done, word_cnt}, {1'b1, 32'd1});
        check("t6_nwr", n_wr - snap, 1);

        tick(4);
        check("sb_left", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mstream_capture.md
# mstream_capture

Receive-side counterpart of the MSTREAM pattern driver. It takes the 20-channel MSTREAM bus after IDDR de-serialisation (rising and falling samples per `clk`) and collapses the padded channels back to 16 data bits. It checks the duplicated pad channels, re-packs eight 32-bit beats into one 256-bit word in the same bit order the driver's w256/r32 FIFO consumes, and writes the words into a capture FIFO. It sits on the loopback/verification path, so host software can read back exactly the pattern stream the sensor saw.

## Interface
Parameters:
- `BEATS_PER_WORD`, 8: 32-bit beats per 256-bit output word; fixed by the 256/32 FIFO ratio.
- `ERRCNT_W`, 16: width of the saturating pad-error counter.

Ports:
- `clk` in 1: single clock for all logic; equals the MSTREAM stream clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that arms a capture run.
- `Num_Pat` in 32: number of 256-bit words to capture; 0 means free-run until `reset`.
- `stream_en` in 1: beat valid, aligned with `mstream_rise`/`mstream_fall`.
- `mstream_rise` in 20: channel samples from the rising edge (D1 side).
- `mstream_fall` in 20: channel samples from the falling edge (D2 side).
- `dout` out 256: packed capture word.
- `wr_en` out 1: capture FIFO write strobe.
- `full` in 1: capture FIFO almost_full.
- `busy` out 1: high in CAPTURE.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; a word was dropped because `full` was high.
- `pad_err` out 1: sticky; a pad-channel mismatch was seen.
- `pad_err_cnt` out ERRCNT_W: beats with a pad mismatch, saturating.
- `word_cnt` out 32: words written (dropped words excluded).

## Operation
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE→CAPTURE on `start`. This clears the beat index, `word_cnt`, `overflow`, `pad_err` and `pad_err_cnt`.
  - CAPTURE→DONE when the Num_Pat-th word has been issued, counting written and dropped words.
  - DONE→CAPTURE on `start`.
  - `start` is ignored while in CAPTURE.
- Beats are accepted only in CAPTURE with `stream_en`=1. In IDLE and DONE, beats are ignored.
- Channel decode per beat:
  - `beat[k]` = `mstream_rise[k+2]`, for k=0..15.
  - `beat[k+16]` = `mstream_fall[k+2]`, for k=0..15.
- Pad check per accepted beat. A mismatch exists if channel 0 or 1 differs from channel 2, or channel 18 or 19 differs from channel 17, on either edge. A mismatch sets `pad_err` and increments `pad_err_cnt`, which holds at all-ones.
- Packing:
  - Beat 0 of a word goes to `dout[255:224]`, beat i to `dout[255-32i -: 32]`, beat 7 to `[31:0]`. This matches the MSB-first read order of the driver's FIFO.
  - The beat index wraps 7→0.
- Write:
  - After beat 7 is accepted, a word is issued.
  - If `full`=0 the word is written: `wr_en`=1 for one cycle and `word_cnt` increments.
  - If `full`=1 the word is dropped: `wr_en` stays 0 and `overflow` is set.
- Gaps: `stream_en` low mid-word holds the partial word and beat index. There is no timeout.
- `Num_Pat`=0: stays in CAPTURE indefinitely. `word_cnt` wraps modulo 2^32.

## Timing
- Reset values: `dout`=0, `wr_en`=0, `busy`=0, `done`=0, `overflow`=0, `pad_err`=0, `pad_err_cnt`=0, `word_cnt`=0. FSM goes to IDLE.
- Reset mid-capture discards any partial word immediately and emits no write.
- `wr_en` and `dout` are registered. They are valid the cycle after beat 7 is accepted.
- Back-to-back beats at full rate give 1 word every 8 cycles with no bubbles.
- `full` is sampled in the same cycle beat 7 is accepted.
- `pad_err` and `pad_err_cnt` update one cycle after the offending beat.
- `done` and `busy` change in the same cycle as the final `wr_en` (or the final drop).
- If `start` arrives in the same cycle as the final beat in CAPTURE, `start` is ignored.

## Structure
- Shared package `mstream_pkg`:
  - constants `MSTREAM_CH`=20, `MSTREAM_DATA`=16, `MSTREAM_PAD_LO`=2, `MSTREAM_PAD_HI`=2;
  - typedef for the FSM state enum.
  The driver side imports the same constants.
- One natural sub-module: `mstream_lane_decode`. It is combinational and produces the 32-bit beat plus a pad-mismatch bit. The packer, FSM and counters live in the top module.

## Test plan
- Reset, `Num_Pat`=2, `start`, then 16 consecutive beats with channel k+2 = bit k of 0x0000A5A5 (rise) and 0x00005A5A (fall). Required: 2 `wr_en` pulses; each `dout` = 8 copies of 0x5A5AA5A5; `done`=1 and `word_cnt`=2.
- Beat i carries 0x11111111·i. Required: `dout[255:224]`=0x00000000, …, `dout[31:0]`=0x77777777.
- Toggle `stream_en` every other cycle over 8 beats. Required: exactly one `wr_en`, and `dout` is identical to the gap-free run.
- Hold `full`=1 on the second word of `Num_Pat`=3. Required: 2 writes, `overflow`=1, `word_cnt`=2, `done`=1.
- Drive channel 19 ≠ channel 17 on 3 beats. Required: `pad_err`=1 and `pad_err_cnt`=3. Data words are unaffected.
- Assert `reset` after beat 4 of a word, then re-`start`. Required: no write from the partial word; the next 8 beats form a clean word.
